// File: rtl/apu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : apu_pkg                                               |
// | Purpose : shared types and constants for the pulse-register     |
// |           serial loader (receiver/parser states, addresses).    |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package apu_pkg;

  localparam int APU_NUM_PULSE_REGS = 8;

  localparam logic [2:0] ADDR_P1_DUTY  = 3'd0;
  localparam logic [2:0] ADDR_P1_SWEEP = 3'd1;
  localparam logic [2:0] ADDR_P1_LO    = 3'd2;
  localparam logic [2:0] ADDR_P1_HI    = 3'd3;
  localparam logic [2:0] ADDR_P2_DUTY  = 3'd4;
  localparam logic [2:0] ADDR_P2_SWEEP = 3'd5;
  localparam logic [2:0] ADDR_P2_LO    = 3'd6;
  localparam logic [2:0] ADDR_P2_HI    = 3'd7;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [0:0] {
    PS_ADDR = 1'b0,
    PS_DATA = 1'b1
  } parse_state_t;

  function automatic logic is_pulse_addr(input logic [7:0] b);
    return b < 8'(APU_NUM_PULSE_REGS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : uart_rx                                               |
// | Purpose : 8N1 UART receiver with 2-flop synchronizer; optional  |
// |           even parity bit when RX_PARITY_EN is defined.         |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module uart_rx
  import apu_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       start_det
);

  localparam int c_CNT_W = $clog2(BAUD_DIV);
  // Edge detection costs one registered cycle, so the half-bit wait is shortened by it.
  localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(BAUD_DIV / 2 - 2);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(BAUD_DIV - 1);

  // [0],[1] synchronize; [2] holds the previous synchronized value. Reset low so
  // the line must be seen high before a falling edge is accepted.
  logic [2:0]         r_sync;
  logic               w_rx;
  logic               w_fall;
  logic               w_par_err;

  rx_state_t          r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;

  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[1:0], rx};
  end

`ifdef RX_PARITY_EN
  logic r_par_err;
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      start_det <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      start_det <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state   <= RX_START;
            r_cnt     <= c_HALF;
            start_det <= 1'b1;
          end
        end
        RX_START: begin
          if (r_cnt == '0) begin
            if (w_rx) begin
              r_state <= RX_IDLE;
            end else begin
              r_state <= RX_DATA;
              r_cnt   <= c_FULL;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= c_FULL;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef RX_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
`ifdef RX_PARITY_EN
        RX_PARITY: begin
          if (r_cnt == '0) begin
            r_par_err <= ^{w_rx, r_shift};
            r_cnt     <= c_FULL;
            r_state   <= RX_STOP;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
`endif
        RX_STOP: begin
          if (r_cnt == '0) begin
            r_state <= RX_IDLE;
            if (w_rx && !w_par_err) begin
              byte_vld <= 1'b1;
              rx_byte  <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/apu_reg_loader.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : apu_reg_loader                                        |
// | Purpose : UART (address,data) frame parser and the eight pulse  |
// |           channel register bytes. RX_PARITY_EN adds even parity.|
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module apu_reg_loader
  import apu_pkg::*;
#(
  parameter int BAUD_DIV     = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] p1_regs,
  output logic [31:0] p2_regs,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic        frame_err
);

  localparam int c_TO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
  localparam int c_TO_W      = $clog2(c_TO_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(c_TO_CYCLES - 1);

  logic              w_byte_vld;
  logic [7:0]        w_byte;
  logic              w_frame_err;
  logic              w_start_det;

  parse_state_t      r_pstate;
  logic [2:0]        r_addr;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [7:0]        r_regs [APU_NUM_PULSE_REGS];

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .byte_vld (w_byte_vld),
    .rx_byte  (w_byte),
    .frame_err(w_frame_err),
    .start_det(w_start_det)
  );

  assign frame_err = w_frame_err;
  assign p1_regs   = {r_regs[ADDR_P1_HI], r_regs[ADDR_P1_LO], r_regs[ADDR_P1_SWEEP], r_regs[ADDR_P1_DUTY]};
  assign p2_regs   = {r_regs[ADDR_P2_HI], r_regs[ADDR_P2_LO], r_regs[ADDR_P2_SWEEP], r_regs[ADDR_P2_DUTY]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pstate <= PS_ADDR;
      r_addr   <= '0;
      r_to_cnt <= '0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      for (int i = 0; i < APU_NUM_PULSE_REGS; i++) r_regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (w_frame_err) begin
        r_pstate <= PS_ADDR;
        r_to_cnt <= '0;
      end else if (w_byte_vld) begin
        r_to_cnt <= '0;
        if (r_pstate == PS_ADDR) begin
          if (is_pulse_addr(w_byte)) begin
            r_addr   <= w_byte[2:0];
            r_pstate <= PS_DATA;
          end
        end else begin
          r_regs[r_addr] <= w_byte;
          wr_addr        <= r_addr;
          wr_stb         <= 1'b1;
          r_pstate       <= PS_ADDR;
        end
      end else if (r_pstate == PS_DATA) begin
        // A new start bit beats a simultaneous expiry.
        if (w_start_det) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt == c_TO_LAST) begin
          r_pstate <= PS_ADDR;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_loader.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module  : tb_apu_reg_loader                                     |
// | Purpose : self-checking bench for apu_reg_loader (BAUD_DIV=16). |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_apu_reg_loader;

  localparam int BD = 16;
  localparam int TB = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] p1_regs;
  logic [31:0] p2_regs;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic        frame_err;

  apu_reg_loader #(
    .BAUD_DIV(BD),
    .TIMEOUT_BITS(TB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .p1_regs  (p1_regs),
    .p2_regs  (p2_regs),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] p1;
    logic [31:0] p2;
  } wr_t;

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] seq;   // first byte sent in [31:24]
    logic [31:0] p1;
    logic [31:0] p2;
    logic [2:0]  addr;
    logic [1:0]  stb;
  } vec_t;

  int  nvec = 0;
  int  nfail = 0;
  int  n_stb = 0;
  int  n_ferr = 0;
  int  cyc = 0;
  int  stb_cyc = 0;
  bit  q_en = 1'b0;
  wr_t exp_q[$];
  wr_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      n_stb++;
      stb_cyc = cyc;
      if (q_en) begin
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr_rand", {29'd0, wr_addr}, {29'd0, e.addr});
          chk("wr_p1_rand", p1_regs, e.p1);
          chk("wr_p2_rand", p2_regs, e.p2);
        end
      end
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  task automatic bits(input int n);
    repeat (n * BD) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    rx = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bits(1);
    end
`ifdef RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    bits(1);
`else
    if (!par_ok) rx = 1'b1;
`endif
    rx = stop_ok;
    bits(1);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bits(1);
    n_stb  = 0;
    n_ferr = 0;
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] seq, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [2:0] addr, input int stb);
    vec_t v;
    v.n = 3'(n); v.seq = seq; v.p1 = p1; v.p2 = p2; v.addr = addr; v.stb = 2'(stb);
    return v;
  endfunction

  vec_t tbl [6];

  initial begin : main
    logic [7:0]  m [8];
    logic [7:0]  b;
    logic [2:0]  ma;
    bit          has_a;
    bit          bad;
    int          e_stb;
    int          e_ferr;
    int          c0;

    tbl[0] = mk(2, 32'h02AB_0000, 32'h00AB_0000, 32'h0000_0000, 3'd2, 1);
    tbl[1] = mk(4, 32'h07F8_043F, 32'h0000_0000, 32'hF800_003F, 3'd4, 2);
    tbl[2] = mk(3, 32'h0905_1100, 32'h0000_0000, 32'h0000_1100, 3'd5, 1);
    tbl[3] = mk(3, 32'h0800_0100, 32'h0000_0001, 32'h0000_0000, 3'd0, 1);
    tbl[4] = mk(4, 32'h03FF_03FF, 32'hFF00_0000, 32'h0000_0000, 3'd3, 2);
    tbl[5] = mk(4, 32'hFF01_00C3, 32'h0000_0000, 32'h0000_0000, 3'd1, 1);

    // Reset state
    do_reset();
    chk("rst_p1", p1_regs, 32'd0);
    chk("rst_p2", p2_regs, 32'd0);
    chk("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);

    // Table of byte sequences from a fresh reset
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int j = 0; j < int'(tbl[t].n); j++) send(tbl[t].seq[31 - 8*j -: 8], 1'b1, 1'b1);
      bits(2);
      chk($sformatf("tbl%0d_p1", t), p1_regs, tbl[t].p1);
      chk($sformatf("tbl%0d_p2", t), p2_regs, tbl[t].p2);
      chk($sformatf("tbl%0d_addr", t), {29'd0, wr_addr}, {29'd0, tbl[t].addr});
      chk($sformatf("tbl%0d_stb", t), 32'(n_stb), 32'(tbl[t].stb));
      chk($sformatf("tbl%0d_ferr", t), 32'(n_ferr), 32'd0);
    end

    // Latency: data byte falling edge to wr_stb
    do_reset();
    send(8'h04, 1'b1, 1'b1);
    #1 c0 = cyc;
    send(8'h5A, 1'b1, 1'b1);
    bits(1);
`ifdef RX_PARITY_EN
    chk("latency", 32'(stb_cyc - c0), 32'd171);
`else
    chk("latency", 32'(stb_cyc - c0), 32'd155);
`endif
    chk("latency_p2", p2_regs, 32'h0000_005A);

    // Timeout abandons the frame
    do_reset();
    send(8'h01, 1'b1, 1'b1);
    repeat (400) @(posedge clk);
    send(8'h03, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b1);
    bits(2);
    chk("timeout_p1", p1_regs, 32'h5500_0000);
    chk("timeout_stb", 32'(n_stb), 32'd1);
    chk("timeout_addr", {29'd0, wr_addr}, 32'd3);

    // Short silence stays within the timeout
    do_reset();
    send(8'h01, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    send(8'h42, 1'b1, 1'b1);
    bits(2);
    chk("no_timeout_p1", p1_regs, 32'h0000_4200);

    // Bad stop bit on the data byte
    do_reset();
    send(8'h02, 1'b1, 1'b1);
    send(8'hAB, 1'b0, 1'b1);
    bits(1);
    chk("badstop_ferr", 32'(n_ferr), 32'd1);
    chk("badstop_stb", 32'(n_stb), 32'd0);
    chk("badstop_p1", p1_regs, 32'd0);
    send(8'h00, 1'b1, 1'b1);
    send(8'h80, 1'b1, 1'b1);
    bits(2);
    chk("after_badstop_p1", p1_regs, 32'h0000_0080);
    chk("after_badstop_stb", 32'(n_stb), 32'd1);

    // Reset in the middle of a data byte
    do_reset();
    send(8'h01, 1'b1, 1'b1);
    send(8'h77, 1'b1, 1'b1);
    send(8'h06, 1'b1, 1'b1);
    chk("pre_rst_p1", p1_regs, 32'h0000_7700);
    n_stb = 0;
    rx = 1'b0;
    bits(1);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h12 >> i) & 8'h01;
      bits(1);
    end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_p1", p1_regs, 32'd0);
    chk("midrst_p2", p2_regs, 32'd0);
    chk("midrst_addr", {29'd0, wr_addr}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    bits(20);
    chk("midrst_stb", 32'(n_stb), 32'd0);
    send(8'h06, 1'b1, 1'b1);
    send(8'h12, 1'b1, 1'b1);
    bits(2);
    chk("after_rst_p2", p2_regs, 32'h0012_0000);
    chk("after_rst_stb", 32'(n_stb), 32'd1);

`ifdef RX_PARITY_EN
    do_reset();
    send(8'h00, 1'b1, 1'b0);
    bits(1);
    chk("par_ferr", 32'(n_ferr), 32'd1);
    chk("par_stb", 32'(n_stb), 32'd0);
`endif

    // Random byte stream against a frame-level model
    do_reset();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    has_a = 1'b0; ma = 3'd0; e_stb = 0; e_ferr = 0;
    q_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      b   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      if (bad) begin
        e_ferr++;
        has_a = 1'b0;
        send(b, 1'b0, 1'b1);
        bits(1);
      end else begin
        if (!has_a) begin
          if (b < 8) begin has_a = 1'b1; ma = b[2:0]; end
        end else begin
          m[ma] = b;
          e_stb++;
          exp_q.push_back('{addr: ma, p1: {m[3], m[2], m[1], m[0]}, p2: {m[7], m[6], m[5], m[4]}});
          has_a = 1'b0;
        end
        send(b, 1'b1, 1'b1);
      end
      bits($urandom_range(0, 2));
    end
    bits(2);
    q_en = 1'b0;
    chk("rand_stb", 32'(n_stb), 32'(e_stb));
    chk("rand_ferr", 32'(n_ferr), 32'(e_ferr));
    chk("rand_p1", p1_regs, {m[3], m[2], m[1], m[0]});
    chk("rand_p2", p2_regs, {m[7], m[6], m[5], m[4]});
    chk("rand_q_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apu_reg_loader.md
# apu_reg_loader

Serial front end that writes the pulse-channel register bytes. It receives 8N1 UART bytes from the host pin, parses them into two-byte (address, data) write frames and holds the eight pulse-channel register bytes (pulse 1: 0–3, pulse 2: 4–7). These bytes drive the `reg_0`..`reg_3` inputs of both pulse channel instances. It is the writer side of the register interface the pulse channels consume.

## Interface
Parameters:
- `BAUD_DIV`, default 104: clock cycles per UART bit. Minimum 4.
- `TIMEOUT_BITS`, default 20: bit-times of line silence after an address byte before the parser abandons the frame.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: UART line, idle high, asynchronous to `clk`.
- `p1_regs` out 32: {reg3, reg2, reg1, reg0} for pulse 1 (addresses 3..0).
- `p2_regs` out 32: {reg3, reg2, reg1, reg0} for pulse 2 (addresses 7..4).
- `wr_stb` out 1: one-cycle pulse on each register write.
- `wr_addr` out 3: address of the last write. Held until the next write.
- `frame_err` out 1: one-cycle pulse when a byte is dropped (bad stop bit, or bad parity with `RX_PARITY_EN`).

## Operation
- `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Receiver states are IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: a high→low edge loads the bit counter and moves to START.
  - START: sample at BAUD_DIV/2 cycles. If high, treat as a glitch and return to IDLE silently.
  - DATA: 8 samples at BAUD_DIV intervals, LSB first.
  - STOP: sample. High gives `byte_vld` for one cycle. Low pulses `frame_err` and drops the byte.
- Parser states are ADDR and DATA.
  - ADDR: a byte 0x00–0x07 latches `addr[2:0]` and moves to DATA. Any other byte is discarded and the parser stays in ADDR.
  - DATA: any byte is written to `regs[addr]`, then the parser returns to ADDR.
  - A `frame_err` in either state forces the parser to ADDR.
  - Timeout: in DATA, a counter runs from the address byte's `byte_vld`. It clears when a new start bit is detected. At TIMEOUT_BITS*BAUD_DIV cycles the parser returns to ADDR.
- Register writes:
  - `regs[addr]`, `wr_addr` and `wr_stb` all update on the same edge.
  - `p1_regs`/`p2_regs` are direct register outputs with no extra stage.
  - A byte-to-field mapping is transparent. Writing the same value again still pulses `wr_stb`.
- Reset values: all regs 0, `wr_stb` 0, `wr_addr` 0, `frame_err` 0, receiver IDLE, parser ADDR. An `rst` assertion mid-byte or mid-frame discards the partial work. After release, the receiver waits for `rx` to be high before it accepts a falling edge.

## Timing
- Start detection: 2 cycles of synchronizer latency after the `rx` fall.
- `byte_vld` occurs at the stop-bit sample: 9.5*BAUD_DIV cycles after the detected edge (10.5 with parity).
- `wr_stb` asserts 1 cycle after the data byte's `byte_vld`. Registered values are visible on the same cycle as `wr_stb`.
- Back-to-back bytes with no idle gap are accepted. The receiver rearms at the stop-bit mid-sample, so it tolerates ±½-bit drift per frame.
- A timeout firing on the same cycle as start detection: start detection wins and the counter clears.

## Configuration
- `RX_PARITY_EN` defined:
  - An even-parity bit is expected between the data bits and the stop bit.
  - A mismatch pulses `frame_err`, drops the byte and resets the parser to ADDR.
- `RX_PARITY_EN` undefined:
  - The frame is 8N1 with no parity state.
  - `frame_err` comes only from a bad stop bit.

## Structure
- Shared package `apu_pkg` holds:
  - the receiver state enum and the parser state enum;
  - `APU_NUM_PULSE_REGS = 8`;
  - register address constants (`ADDR_P1_DUTY = 0` … `ADDR_P2_HI = 7`).
- One sub-module, `uart_rx`: synchronizer, bit timing, optional parity, emits `byte_vld`/`byte`/`frame_err`.
- The parser, timeout counter and register file live in `apu_reg_loader`.

## Test plan
All scenarios use BAUD_DIV=16, TIMEOUT_BITS=20.
- Send 0x02 then 0xAB: one `wr_stb` with `wr_addr`=2, `p1_regs`=0x00AB0000, `p2_regs` unchanged at 0.
- Send 0x07, 0xF8, then 0x04, 0x3F back-to-back: two strobes. `p2_regs`=0xF800003F.
- Send 0x09, 0x05, 0x11:
  - 0x09 is discarded and the parser stays in ADDR.
  - 0x05 is taken as an address and 0x11 as its data.
  - Result: `p2_regs[15:8]`=0x11, exactly one `wr_stb`.
- Send 0x01, then hold `rx` high for 400 cycles, then send 0x03, 0x55:
  - The parser times out after the 0x01 address byte.
  - 0x03 is taken as a fresh address; 0x55 goes to `reg3` of pulse 1.
  - `p1_regs`=0x55000000.
- Corrupt the stop bit of a data byte (held low): `frame_err` pulses once with no write. The next valid pair 0x00, 0x80 writes `p1_regs[7:0]`=0x80.
- Assert `rst` at bit 4 of a data byte following address 0x06:
  - All outputs are 0 and no `wr_stb` occurs.
  - After release, 0x06, 0x12 gives `p2_regs`=0x00120000.
  - With `RX_PARITY_EN`: send 0x00 with odd parity → `frame_err`, no write.
